// File: rtl/rf_result_checker_pkg.sv
// rf_result_checker_pkg
// Shared definitions for the register-file result checker:
//   - state_t     : checker FSM state encoding
//   - DEF_*       : default parameter values
//   - addr_width  : index width helper that never returns 0
package rf_result_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_PASS  = 2'd2,
        ST_FAIL  = 2'd3
    } state_t;

    localparam int DEF_DWIDTH  = 16;
    localparam int DEF_NREG    = 4;
    localparam int DEF_DEPTH   = 8;
    localparam int DEF_TIMEOUT = 100;

    // A single-entry table or register file still needs a 1-bit index.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_result_checker_if.sv
// rf_result_checker_if
// Bundles the configuration, register-file snapshot and status signals of
// rf_result_checker.
//   master : test harness side (drives cfg_*, start, rf_flat; reads status)
//   slave  : checker side
// Signals: cfg_we, cfg_idx, cfg_reg, cfg_data, cfg_num, start, rf_flat,
//          busy, done, pass, fail, test_id, fail_got, fail_exp, wait_cnt
interface rf_result_checker_if
    import rf_result_checker_pkg::*;
#(
    parameter int DWIDTH  = DEF_DWIDTH,
    parameter int NREG    = DEF_NREG,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
);
    localparam int RAW = addr_width(NREG);
    localparam int IAW = addr_width(DEPTH);
    localparam int CW  = $clog2(TIMEOUT + 1);

    logic                   cfg_we;
    logic [IAW-1:0]         cfg_idx;
    logic [RAW-1:0]         cfg_reg;
    logic [DWIDTH-1:0]      cfg_data;
    logic [IAW:0]           cfg_num;
    logic                   start;
    logic [NREG*DWIDTH-1:0] rf_flat;

    logic                   busy;
    logic                   done;
    logic                   pass;
    logic                   fail;
    logic [IAW:0]           test_id;
    logic [DWIDTH-1:0]      fail_got;
    logic [DWIDTH-1:0]      fail_exp;
    logic [CW-1:0]          wait_cnt;

    modport master (
        output cfg_we, cfg_idx, cfg_reg, cfg_data, cfg_num, start, rf_flat,
        input  busy, done, pass, fail, test_id, fail_got, fail_exp, wait_cnt
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_reg, cfg_data, cfg_num, start, rf_flat,
        output busy, done, pass, fail, test_id, fail_got, fail_exp, wait_cnt
    );

endinterface

// File: rtl/rf_check_table.sv
// rf_check_table
// Expectation table: each entry is {register index, expected value}.
// One synchronous write port, one asynchronous read port, and every entry
// is cleared by reset.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   we, waddr           : write enable and entry index
//   wreg, wdata         : register index / expected value to store
//   raddr               : read entry index
//   rreg, rdata         : register index / expected value of entry raddr
module rf_check_table
    import rf_result_checker_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int NREG   = DEF_NREG,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                we,
    input  logic [addr_width(DEPTH)-1:0]        waddr,
    input  logic [addr_width(NREG)-1:0]         wreg,
    input  logic [DWIDTH-1:0]                   wdata,
    input  logic [addr_width(DEPTH)-1:0]        raddr,
    output logic [addr_width(NREG)-1:0]         rreg,
    output logic [DWIDTH-1:0]                   rdata
);
    localparam int RAW  = addr_width(NREG);
    localparam int IAW  = addr_width(DEPTH);
    // Rounded up to the full index range so any index is a legal access;
    // the checker only ever uses the first DEPTH rows.
    localparam int ROWS = 2 ** IAW;

    logic [RAW+DWIDTH-1:0] mem [ROWS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROWS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= {wreg, wdata};
        end
    end

    assign {rreg, rdata} = mem[raddr];

endmodule

// File: rtl/rf_result_checker.sv
// rf_result_checker
// Walks an expectation table entry by entry, waiting for each selected CPU
// register to reach its expected value. Each entry has TIMEOUT cycles to
// match; a miss ends the run in FAIL with the observed/expected values
// captured, otherwise the run ends in PASS.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rf_result_checker_if.slave (config, snapshot, status)
module rf_result_checker
    import rf_result_checker_pkg::*;
#(
    parameter int DWIDTH  = DEF_DWIDTH,
    parameter int NREG    = DEF_NREG,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rf_result_checker_if.slave   bus
);
    localparam int RAW = addr_width(NREG);
    localparam int IAW = addr_width(DEPTH);
    localparam int NW  = IAW + 1;
    localparam int CW  = $clog2(TIMEOUT + 1);

    localparam logic [NW-1:0] NUM_MAX   = NW'(DEPTH);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    state_t             state_q,   state_d;
    logic [NW-1:0]      num_q,     num_d;
    logic [NW-1:0]      test_id_q, test_id_d;
    logic [CW-1:0]      wait_q,    wait_d;
    logic [DWIDTH-1:0]  got_q,     got_d;
    logic [DWIDTH-1:0]  exp_q,     exp_d;

    logic [RAW-1:0]     exp_reg;
    logic [DWIDTH-1:0]  exp_data;
    logic [DWIDTH-1:0]  observed;
    logic [NW-1:0]      num_sat;
    logic [NW-1:0]      test_id_inc;
    logic               match;
    logic               table_we;

    // The table is frozen while a run is walking it.
    assign table_we = bus.cfg_we && (state_q != ST_CHECK);

    rf_check_table #(
        .DWIDTH (DWIDTH),
        .NREG   (NREG),
        .DEPTH  (DEPTH)
    ) u_table (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (table_we),
        .waddr (bus.cfg_idx),
        .wreg  (bus.cfg_reg),
        .wdata (bus.cfg_data),
        .raddr (test_id_q[IAW-1:0]),
        .rreg  (exp_reg),
        .rdata (exp_data)
    );

    // Register mux; an index past the last real register reads as zero.
    always_comb begin
        observed = '0;
        for (int k = 0; k < NREG; k++) begin
            if (int'(exp_reg) == k) begin
                observed = bus.rf_flat[k*DWIDTH +: DWIDTH];
            end
        end
    end

    assign match       = (observed == exp_data);
    assign num_sat     = (bus.cfg_num > NUM_MAX) ? NUM_MAX : bus.cfg_num;
    assign test_id_inc = test_id_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        test_id_d = test_id_q;
        wait_d    = wait_q;
        got_d     = got_q;
        exp_d     = exp_q;
        case (state_q)
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (bus.start) begin
                    num_d     = num_sat;
                    test_id_d = '0;
                    wait_d    = '0;
                    got_d     = '0;
                    exp_d     = '0;
                    state_d   = (num_sat == '0) ? ST_PASS : ST_CHECK;
                end
            end
            ST_CHECK: begin
                // A match always wins, even on the last allowed cycle.
                if (match) begin
                    test_id_d = test_id_inc;
                    wait_d    = '0;
                    if (test_id_inc == num_q) begin
                        state_d = ST_PASS;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                    if (wait_q == WAIT_LAST) begin
                        state_d = ST_FAIL;
                        got_d   = observed;
                        exp_d   = exp_data;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q     <= '0;
            test_id_q <= '0;
            wait_q    <= '0;
            got_q     <= '0;
            exp_q     <= '0;
        end else begin
            num_q     <= num_d;
            test_id_q <= test_id_d;
            wait_q    <= wait_d;
            got_q     <= got_d;
            exp_q     <= exp_d;
        end
    end

    assign bus.busy     = (state_q == ST_CHECK);
    assign bus.done     = (state_q == ST_PASS) || (state_q == ST_FAIL);
    assign bus.pass     = (state_q == ST_PASS);
    assign bus.fail     = (state_q == ST_FAIL);
    assign bus.test_id  = test_id_q;
    assign bus.wait_cnt = wait_q;
    assign bus.fail_got = got_q;
    assign bus.fail_exp = exp_q;

endmodule
